switch_poller: RTL and testbench
================================

# switch_poller

Avalon-MM initiator that owns the switch PIO read path: it periodically reads the 10-bit switch register (address 0, fixed one-cycle read latency, no waitrequest), debounces the samples, and presents a stable switch vector plus latched rise/fall events to the game-control logic through a valid/ack handshake. It replaces per-frame software polling of the switch port.

## Interface
- WIDTH, 10, switch vector width; matches PIO readdata width.
- POLL_DIV, 50000, clock cycles between read strobes (1 ms at 50 MHz); must be ≥ 3.
- STABLE_COUNT, 4, consecutive identical samples required to accept a new value; must be ≥ 1.
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- address  out  2  PIO address; always 0 when read is high.
- read  out  1  one-cycle read strobe to the PIO.
- readdata  in  WIDTH  PIO read data, valid the cycle after read.
- sw_state  out  WIDTH  debounced switch vector.
- evt_valid  out  1  pending change event.
- evt_rise  out  WIDTH  bits that went 0→1 since last ack.
- evt_fall  out  WIDTH  bits that went 1→0 since last ack.
- evt_overrun  out  1  more than one update merged into the pending event.
- evt_ack  in  1  consumer acknowledge; effective only while evt_valid.

## Operation
- Free-running poll timer counts POLL_DIV-1 down to 0 and reloads; terminal count is the tick. Timer never stalls.
- FSM states IDLE, REQ, SAMPLE. IDLE→REQ on tick; REQ (read=1, address=0) → SAMPLE unconditionally; SAMPLE (readdata captured at end of cycle) → IDLE.
- Debounce: registers candidate and match_cnt (saturating at STABLE_COUNT). On sample: equal to candidate → match_cnt+1 (saturate); different → candidate=sample, match_cnt=1.
- Update when match_cnt reaches STABLE_COUNT this sample and candidate ≠ sw_state: sw_state=candidate, rise=candidate & ~sw_state, fall=~candidate & sw_state. No update when candidate equals sw_state.
- Event latch: update with evt_valid=0 → evt_valid=1, masks=rise/fall, overrun=0. Update with evt_valid=1 and no ack → masks OR-accumulate, evt_overrun=1. Ack without update → evt_valid, masks, overrun cleared. Ack and update same cycle → evt_valid stays 1, masks = new rise/fall only, overrun=0.
- Bit that rises then falls before ack shows in both evt_rise and evt_fall.

## Timing
- Reset values: read=0, address=0, sw_state=0, evt_valid=0, evt_rise=0, evt_fall=0, evt_overrun=0; FSM=IDLE, timer=POLL_DIV-1, candidate=0, match_cnt=0.
- First read at cycle POLL_DIV-1 after reset release (cycle 0 = first cycle with reset low); then every POLL_DIV cycles exactly.
- read asserted in cycle T, readdata sampled end of T+1, sw_state/evt_* change visible in T+2.
- Minimum debounce latency from stable input to sw_state: (STABLE_COUNT-1)·POLL_DIV + 2 cycles after the first matching read.
- Switches already high at power-up produce a normal rise event after STABLE_COUNT samples.
- Reset mid-poll (REQ or SAMPLE) aborts the read; any in-flight readdata is discarded.

## Structure
- Shared package switch_poller_pkg: FSM state encoding (IDLE/REQ/SAMPLE), PIO_SWITCH_ADDR = 2'd0.
- One sub-module switch_debounce: candidate/match_cnt/sw_state with rise/fall/update outputs; top holds timer, FSM, event latch.
- Counter widths via $clog2(POLL_DIV) and $clog2(STABLE_COUNT+1).

## Test plan
- POLL_DIV=8, STABLE_COUNT=3, readdata model with 1-cycle latency: reset release → read pulses at cycles 7, 15, 23, address=0 each, read high exactly one cycle.
- Switches 10'h005 steady → sw_state=10'h005 at cycle 25 (third sample +2), evt_valid=1, evt_rise=10'h005, evt_fall=0, overrun=0.
- Bounce: samples 0x001,0x000,0x001,0x001,0x001 → single update to 0x001 only after third consecutive 0x001; no event before.
- No ack: 0x000→0x003, then →0x002 → evt_rise=10'h003, evt_fall=10'h001, evt_overrun=1; evt_ack → all cleared next cycle.
- evt_ack in the same cycle as a new update (0x002→0x006) → evt_valid stays 1, evt_rise=10'h004, evt_fall=0, overrun=0.
- Reset asserted during SAMPLE cycle → all outputs at reset values next cycle; next read at cycle POLL_DIV-1 after release.

Source files
------------

// File: rtl/switch_poller_pkg.sv
// switch_poller_pkg
//   Shared definitions for the switch poller: the poll FSM state encoding
//   and the PIO register address of the switch port.
package switch_poller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // waiting for the poll timer
    ST_REQ    = 2'd1,  // read strobe on the bus
    ST_SAMPLE = 2'd2   // readdata is valid this cycle
  } poll_state_t;

  localparam logic [1:0] PIO_SWITCH_ADDR = 2'd0;

endpackage

// File: rtl/switch_poller_debounce.sv
// switch_debounce
//   Accepts a new switch vector only after STABLE_COUNT consecutive identical
//   samples. It reports the accepting sample as a combinational update pulse,
//   together with the rise and fall masks relative to the current debounced
//   value, so the event latch can register them on the same edge.
//
// Ports
//   clk, reset  system clock, synchronous active-high reset
//   sample_en   sample is valid this cycle
//   sample      raw switch sample (PIO readdata)
//   sw_state    debounced switch vector
//   update      sw_state takes the value of sample at the end of this cycle
//   rise, fall  bits going 0->1 / 1->0 on that update
module switch_debounce #(
  parameter int WIDTH        = 10,
  parameter int STABLE_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] sw_state,
  output logic             update,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int            CW      = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_COUNT);

  logic [WIDTH-1:0] candidate;
  logic [CW-1:0]    match_cnt;
  logic [CW-1:0]    match_cnt_next;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    match_cnt_next = match_cnt;
    if (sample == candidate) begin
      if (match_cnt != CNT_MAX) match_cnt_next = match_cnt + CW'(1);
    end else begin
      match_cnt_next = CW'(1);
    end
  end

  // A new candidate always equals the sample itself, so the sample can be
  // compared with sw_state directly.
  assign update = sample_en && (match_cnt_next == CNT_MAX) && (sample != sw_state);
  assign rise   = sample & ~sw_state;
  assign fall   = ~sample & sw_state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the values from before the clock edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      candidate <= '0;
      match_cnt <= '0;
      sw_state  <= '0;
    end else if (sample_en) begin
      candidate <= sample;
      match_cnt <= match_cnt_next;
      if (update) sw_state <= sample;
    end
  end

endmodule

// File: rtl/switch_poller.sv
// switch_poller
//   Avalon-MM initiator that polls the switch PIO every POLL_DIV cycles,
//   debounces the samples and presents the stable vector plus latched
//   rise/fall events through a valid/ack handshake.
//   POLL_DIV must be at least 3 so that a read completes before the next tick.
//
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   address      PIO address (always the switch register)
//   read         one-cycle read strobe
//   readdata     PIO read data, valid the cycle after read
//   sw_state     debounced switch vector
//   evt_valid    a change event is pending
//   evt_rise     bits that went 0->1 since the last ack
//   evt_fall     bits that went 1->0 since the last ack
//   evt_overrun  more than one update was merged into the pending event
//   evt_ack      consumer acknowledge, effective only while evt_valid
module switch_poller
  import switch_poller_pkg::*;
#(
  parameter int WIDTH        = 10,
  parameter int POLL_DIV     = 50000,
  parameter int STABLE_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [1:0]       address,
  output logic             read,
  input  logic [WIDTH-1:0] readdata,
  output logic [WIDTH-1:0] sw_state,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_rise,
  output logic [WIDTH-1:0] evt_fall,
  output logic             evt_overrun,
  input  logic             evt_ack
);

  localparam int            TW     = $clog2(POLL_DIV);
  localparam logic [TW-1:0] RELOAD = TW'(POLL_DIV - 1);

  logic [TW-1:0] timer;
  logic          pre_tick;
  poll_state_t   state, state_next;

  logic             update;
  logic [WIDTH-1:0] rise, fall;
  logic             ack_eff;

  // Free-running poll timer; terminal count (0) is the tick.
  always_ff @(posedge clk) begin
    if (reset || timer == '0) timer <= RELOAD;
    else                      timer <= timer - TW'(1);
  end

  // The FSM leaves IDLE one count early so the REQ cycle coincides with the
  // terminal count, putting the first read exactly POLL_DIV-1 cycles after
  // reset release.
  assign pre_tick = (timer == TW'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (pre_tick) state_next = ST_REQ;
      ST_REQ:    state_next = ST_SAMPLE;
      ST_SAMPLE: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    read    = (state == ST_REQ);
    address = PIO_SWITCH_ADDR;
  end

  switch_debounce #(
    .WIDTH        (WIDTH),
    .STABLE_COUNT (STABLE_COUNT)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .sample_en (state == ST_SAMPLE),
    .sample    (readdata),
    .sw_state  (sw_state),
    .update    (update),
    .rise      (rise),
    .fall      (fall)
  );

  assign ack_eff = evt_ack && evt_valid;

  // Event latch: an unacknowledged pending event absorbs further updates and
  // flags the merge; an ack arriving with an update hands over a fresh event.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid   <= 1'b0;
      evt_rise    <= '0;
      evt_fall    <= '0;
      evt_overrun <= 1'b0;
    end else if (update) begin
      evt_valid <= 1'b1;
      if (evt_valid && !ack_eff) begin
        evt_rise    <= evt_rise | rise;
        evt_fall    <= evt_fall | fall;
        evt_overrun <= 1'b1;
      end else begin
        evt_rise    <= rise;
        evt_fall    <= fall;
        evt_overrun <= 1'b0;
      end
    end else if (ack_eff) begin
      evt_valid   <= 1'b0;
      evt_rise    <= '0;
      evt_fall    <= '0;
      evt_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_poller.sv
// tb_switch_poller
//   Self-checking bench for switch_poller with POLL_DIV=8, STABLE_COUNT=3.
//   A PIO responder returns the switch value one cycle after each read and
//   random junk otherwise. A reference model tracks the read schedule, the
//   last three samples and the pending event from the behavioural rules.
module tb_switch_poller;

  localparam int WIDTH = 10;
  localparam int PD    = 8;
  localparam int SC    = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       address;
  logic             read;
  logic [WIDTH-1:0] readdata = '0;
  logic [WIDTH-1:0] sw_state;
  logic             evt_valid;
  logic [WIDTH-1:0] evt_rise;
  logic [WIDTH-1:0] evt_fall;
  logic             evt_overrun;
  logic             evt_ack = 1'b0;
  logic [WIDTH-1:0] sw_in = '0;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  switch_poller #(
    .WIDTH        (WIDTH),
    .POLL_DIV     (PD),
    .STABLE_COUNT (SC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .read        (read),
    .readdata    (readdata),
    .sw_state    (sw_state),
    .evt_valid   (evt_valid),
    .evt_rise    (evt_rise),
    .evt_fall    (evt_fall),
    .evt_overrun (evt_overrun),
    .evt_ack     (evt_ack)
  );

  always #5 clk = ~clk;

  // PIO responder: valid data only in the cycle after a read.
  always @(posedge clk) readdata <= read ? sw_in : WIDTH'($urandom);

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [31:0]      cyc;       // cycles since reset release
    logic [9:0]       read_val;  // switch value captured by the last read
    logic [2:0][9:0]  hist;      // last three samples, [0] newest
    logic [3:0]       nsamp;     // samples seen, saturating at SC
    logic [9:0]       state;
    logic [9:0]       rise;
    logic [9:0]       fall;
    logic             valid;
    logic             ovr;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t cur, logic rst, logic [9:0] sw, logic ack);
    model_t     n;
    logic [9:0] s, r, f;
    logic       upd;
    n = cur; upd = 1'b0; r = '0; f = '0; s = '0;
    if (rst) begin
      n = '0;
      return n;
    end
    n.cyc = cur.cyc + 1;
    if (cur.cyc % PD == PD - 1) n.read_val = sw;
    if (cur.cyc % PD == 0 && cur.cyc != 0) begin
      s = cur.read_val;
      n.hist = {cur.hist[1:0], s};
      if (cur.nsamp < SC) n.nsamp = cur.nsamp + 1;
      if (n.nsamp == SC && n.hist[0] == n.hist[1] && n.hist[1] == n.hist[2] && s != cur.state) begin
        upd = 1'b1;
        r = s & ~cur.state;
        f = ~s & cur.state;
        n.state = s;
      end
    end
    if (upd) begin
      n.valid = 1'b1;
      if (cur.valid && !ack) begin
        n.rise = cur.rise | r;
        n.fall = cur.fall | f;
        n.ovr  = 1'b1;
      end else begin
        n.rise = r;
        n.fall = f;
        n.ovr  = 1'b0;
      end
    end else if (ack && cur.valid) begin
      n.valid = 1'b0;
      n.rise  = '0;
      n.fall  = '0;
      n.ovr   = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_step(m, reset, sw_in, evt_ack);

  function automatic logic [34:0] exp_vec();
    return {(m.cyc % PD) == (PD - 1), 2'b00, m.state, m.valid, m.rise, m.fall, m.ovr};
  endfunction

  wire [34:0] dut_vec = {read, address, sw_state, evt_valid, evt_rise, evt_fall, evt_overrun};

  // ---------------------------------------------------------------- helpers
  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Returns at the start of cycle 0 (first cycle with reset low).
  task automatic do_reset(input int n);
    reset = 1'b1;
    evt_ack = 1'b0;
    repeat (n) advance();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b1; evt_ack = 1'b0; sw_in = 10'h3ff;
    repeat (3) advance();
    @(negedge clk);
    chk_cnt++;
    if (dut_vec !== 35'd0) $display("FAIL reset_values: got %h expected %h", dut_vec, 35'd0);
    else pass_cnt++;
  endtask

  task automatic test_read_schedule();
    sw_in = 10'h155;
    do_reset(2);
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      chk_cnt++;
      if (read !== (c == 7 || c == 15 || c == 23))
        $display("FAIL read_schedule c%0d: read=%b expected %b", c, read, (c == 7 || c == 15 || c == 23));
      else pass_cnt++;
      if (c == 7 || c == 15 || c == 23) begin
        chk_cnt++;
        if (address !== 2'd0) $display("FAIL read_address c%0d: got %0d expected 0", c, address);
        else pass_cnt++;
      end
      advance();
    end
  endtask

  task automatic test_steady();
    sw_in = 10'h005;
    do_reset(2);
    for (int c = 0; c <= 26; c++) begin
      @(negedge clk);
      if (c == 24) begin
        chk_cnt++;
        if ({sw_state, evt_valid} !== {10'h000, 1'b0})
          $display("FAIL steady_early: sw_state=%h valid=%b expected 000/0", sw_state, evt_valid);
        else pass_cnt++;
      end
      if (c == 25) begin
        chk_cnt++;
        if ({sw_state, evt_valid, evt_rise, evt_fall, evt_overrun} !== {10'h005, 1'b1, 10'h005, 10'h000, 1'b0})
          $display("FAIL steady_update: state=%h v=%b r=%h f=%h o=%b expected 005/1/005/000/0",
                   sw_state, evt_valid, evt_rise, evt_fall, evt_overrun);
        else pass_cnt++;
      end
      chk_cnt++;
      if (dut_vec !== exp_vec()) $display("FAIL steady_model c%0d: dut=%h model=%h", c, dut_vec, exp_vec());
      else pass_cnt++;
      advance();
    end
  endtask

  task automatic test_bounce();
    logic [9:0] pat [5];
    pat = '{10'h001, 10'h000, 10'h001, 10'h001, 10'h001};
    sw_in = pat[0];
    do_reset(2);
    for (int c = 0; c <= 42; c++) begin
      if (c % PD == 0 && c / PD < 5) sw_in = pat[c / PD];
      @(negedge clk);
      if (c == 40) begin
        chk_cnt++;
        if ({sw_state, evt_valid} !== {10'h000, 1'b0})
          $display("FAIL bounce_hold: sw_state=%h valid=%b expected 000/0", sw_state, evt_valid);
        else pass_cnt++;
      end
      if (c == 41) begin
        chk_cnt++;
        if ({sw_state, evt_valid, evt_rise, evt_fall} !== {10'h001, 1'b1, 10'h001, 10'h000})
          $display("FAIL bounce_update: state=%h v=%b r=%h f=%h expected 001/1/001/000",
                   sw_state, evt_valid, evt_rise, evt_fall);
        else pass_cnt++;
      end
      chk_cnt++;
      if (dut_vec !== exp_vec()) $display("FAIL bounce_model c%0d: dut=%h model=%h", c, dut_vec, exp_vec());
      else pass_cnt++;
      advance();
    end
  endtask

  task automatic test_overrun();
    sw_in = 10'h003;
    do_reset(2);
    for (int c = 0; c <= 52; c++) begin
      if (c == 25) sw_in = 10'h002;
      evt_ack = (c == 50);
      @(negedge clk);
      if (c == 49) begin
        chk_cnt++;
        if ({sw_state, evt_valid, evt_rise, evt_fall, evt_overrun} !== {10'h002, 1'b1, 10'h003, 10'h001, 1'b1})
          $display("FAIL overrun_merge: state=%h v=%b r=%h f=%h o=%b expected 002/1/003/001/1",
                   sw_state, evt_valid, evt_rise, evt_fall, evt_overrun);
        else pass_cnt++;
      end
      if (c == 51) begin
        chk_cnt++;
        if ({evt_valid, evt_rise, evt_fall, evt_overrun} !== {1'b0, 10'h000, 10'h000, 1'b0})
          $display("FAIL overrun_ack_clear: v=%b r=%h f=%h o=%b expected all zero",
                   evt_valid, evt_rise, evt_fall, evt_overrun);
        else pass_cnt++;
      end
      chk_cnt++;
      if (dut_vec !== exp_vec()) $display("FAIL overrun_model c%0d: dut=%h model=%h", c, dut_vec, exp_vec());
      else pass_cnt++;
      advance();
    end
    evt_ack = 1'b0;
  endtask

  task automatic test_ack_collision();
    sw_in = 10'h002;
    do_reset(2);
    for (int c = 0; c <= 50; c++) begin
      if (c == 25) sw_in = 10'h006;
      evt_ack = (c == 48);
      @(negedge clk);
      if (c == 48) begin
        chk_cnt++;
        if ({evt_valid, evt_rise} !== {1'b1, 10'h002})
          $display("FAIL collide_pending: v=%b r=%h expected 1/002", evt_valid, evt_rise);
        else pass_cnt++;
      end
      if (c == 49) begin
        chk_cnt++;
        if ({sw_state, evt_valid, evt_rise, evt_fall, evt_overrun} !== {10'h006, 1'b1, 10'h004, 10'h000, 1'b0})
          $display("FAIL collide_update: state=%h v=%b r=%h f=%h o=%b expected 006/1/004/000/0",
                   sw_state, evt_valid, evt_rise, evt_fall, evt_overrun);
        else pass_cnt++;
      end
      chk_cnt++;
      if (dut_vec !== exp_vec()) $display("FAIL collide_model c%0d: dut=%h model=%h", c, dut_vec, exp_vec());
      else pass_cnt++;
      advance();
    end
    evt_ack = 1'b0;
  endtask

  task automatic test_reset_mid_poll();
    sw_in = 10'h3ff;
    do_reset(2);
    for (int c = 0; c <= 23; c++) advance();
    reset = 1'b1;          // cycle 24 is the SAMPLE cycle of the third read
    @(negedge clk);
    advance();
    reset = 1'b0;          // this cycle is cycle 0 after release
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk_cnt++;
        if (dut_vec !== 35'd0) $display("FAIL midpoll_reset: got %h expected %h", dut_vec, 35'd0);
        else pass_cnt++;
      end
      if (k <= 8) begin
        chk_cnt++;
        if (read !== (k == 7)) $display("FAIL midpoll_read k%0d: read=%b expected %b", k, read, (k == 7));
        else pass_cnt++;
      end
      chk_cnt++;
      if (dut_vec !== exp_vec()) $display("FAIL midpoll_model k%0d: dut=%h model=%h", k, dut_vec, exp_vec());
      else pass_cnt++;
      advance();
    end
  endtask

  task automatic test_random();
    sw_in = WIDTH'($urandom);
    do_reset(2);
    for (int c = 0; c < 2000; c++) begin
      if (c % PD == 0) begin
        if ($urandom_range(0, 9) < 3)      sw_in = WIDTH'($urandom);
        else if ($urandom_range(0, 9) < 2) sw_in = sw_in ^ (10'h001 << $urandom_range(0, WIDTH - 1));
      end
      evt_ack = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      chk_cnt++;
      if (dut_vec !== exp_vec()) $display("FAIL random_model c%0d: dut=%h model=%h", c, dut_vec, exp_vec());
      else pass_cnt++;
      advance();
    end
    evt_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_schedule();
    test_steady();
    test_bounce();
    test_overrun();
    test_ack_collision();
    test_reset_mid_poll();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
